// File: rtl/ssm_tile_feeder.sv
// Captures one full SSM group and replays it as TPG consecutive N_TILE-wide tiles.
// The last tile is zero-padded. Back-to-back groups stream with no idle cycle.
module ssm_tile_row_slice #(
  parameter int DW      = 16,
  parameter int N_TILE  = 64,
  parameter int N_TOTAL = 128,
  parameter int TPG     = 2,
  parameter int CW      = 1
) (
  input  logic [CW-1:0]          idx,
  input  logic [N_TOTAL*DW-1:0]  row,
  output logic [N_TILE*DW-1:0]   tile
);
  localparam int PADW = TPG*N_TILE*DW;

  // Zero-extension supplies the padding beyond N_TOTAL.
  logic [TPG-1:0][N_TILE*DW-1:0] pad;
  assign pad = PADW'(row);

  always_comb begin
    tile = '0;
    for (int t = 0; t < TPG; t++)
      if (idx == CW'(t)) tile = pad[t];
  end
endmodule

module ssm_tile_feeder #(
  parameter int DW      = 16,
  parameter int H_TILE  = 1,
  parameter int P_TILE  = 1,
  parameter int N_TILE  = 64,
  parameter int N_TOTAL = 128,
  localparam int TPG    = (N_TOTAL + N_TILE - 1) / N_TILE,
  localparam int CW     = (TPG > 1) ? $clog2(TPG) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              grp_valid_i,
  output logic                              grp_ready_o,
  input  logic [H_TILE*DW-1:0]              dt_i,
  input  logic [H_TILE*DW-1:0]              dt_bias_i,
  input  logic [H_TILE*DW-1:0]              A_i,
  input  logic [H_TILE*DW-1:0]              D_i,
  input  logic [H_TILE*P_TILE*DW-1:0]       x_i,
  input  logic [N_TOTAL*DW-1:0]             B_i,
  input  logic [N_TOTAL*DW-1:0]             C_i,
  input  logic [H_TILE*P_TILE*N_TOTAL*DW-1:0] hprev_i,
  output logic                              tile_valid_o,
  input  logic                              tile_ready_i,
  output logic [H_TILE*DW-1:0]              dt_o,
  output logic [H_TILE*DW-1:0]              dt_bias_o,
  output logic [H_TILE*DW-1:0]              A_o,
  output logic [H_TILE*DW-1:0]              D_o,
  output logic [H_TILE*P_TILE*DW-1:0]       x_o,
  output logic [N_TILE*DW-1:0]              B_tile_o,
  output logic [N_TILE*DW-1:0]              C_tile_o,
  output logic [H_TILE*P_TILE*N_TILE*DW-1:0] hprev_tile_o,
  output logic [CW-1:0]                     tile_idx_o,
  output logic                              tile_first_o,
  output logic                              tile_last_o,
  output logic                              busy_o
);
  localparam int HP = H_TILE*P_TILE;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(TPG-1);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          accept;

  logic [H_TILE*DW-1:0]          dt_q, dt_bias_q, a_q, d_q;
  logic [HP*DW-1:0]              x_q;
  logic [N_TOTAL*DW-1:0]         b_q, c_q;
  logic [HP-1:0][N_TOTAL*DW-1:0] hprev_q;

  // Ready on the last tile's handshake lets the next group slot in without a bubble.
  assign grp_ready_o = (state == IDLE) | ((state == STREAM) & (cnt == LAST) & tile_ready_i);
  assign accept      = grp_valid_i & grp_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (accept) begin
      state <= STREAM;
      cnt   <= '0;
    end else if ((state == STREAM) && tile_ready_i) begin
      if (cnt == LAST) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_q      <= '0;
      dt_bias_q <= '0;
      a_q       <= '0;
      d_q       <= '0;
      x_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      hprev_q   <= '0;
    end else if (accept) begin
      dt_q      <= dt_i;
      dt_bias_q <= dt_bias_i;
      a_q       <= A_i;
      d_q       <= D_i;
      x_q       <= x_i;
      b_q       <= B_i;
      c_q       <= C_i;
      hprev_q   <= hprev_i;
    end
  end

  assign dt_o         = dt_q;
  assign dt_bias_o    = dt_bias_q;
  assign A_o          = a_q;
  assign D_o          = d_q;
  assign x_o          = x_q;
  assign tile_valid_o = (state == STREAM);
  assign busy_o       = (state == STREAM);
  assign tile_idx_o   = cnt;
  assign tile_first_o = tile_valid_o & (cnt == '0);
  assign tile_last_o  = tile_valid_o & (cnt == LAST);

  ssm_tile_row_slice #(.DW(DW), .N_TILE(N_TILE), .N_TOTAL(N_TOTAL), .TPG(TPG), .CW(CW))
    u_b (.idx(cnt), .row(b_q), .tile(B_tile_o));
  ssm_tile_row_slice #(.DW(DW), .N_TILE(N_TILE), .N_TOTAL(N_TOTAL), .TPG(TPG), .CW(CW))
    u_c (.idx(cnt), .row(c_q), .tile(C_tile_o));

  for (genvar r = 0; r < HP; r++) begin : g_hp
    logic [N_TILE*DW-1:0] t_row;
    ssm_tile_row_slice #(.DW(DW), .N_TILE(N_TILE), .N_TOTAL(N_TOTAL), .TPG(TPG), .CW(CW))
      u_h (.idx(cnt), .row(hprev_q[r]), .tile(t_row));
    assign hprev_tile_o[r*N_TILE*DW +: N_TILE*DW] = t_row;
  end
endmodule

// File: tb/tb_ssm_tile_feeder.sv
// Bench for ssm_tile_feeder: three instances (N_TOTAL 128/100/64) share stimulus and are
// checked every cycle against a tiles-remaining model, plus directed vectors and sequences.
module tb_ssm_tile_feeder;
  localparam int DW = 16, NT = 64, NMAX = 128;

  logic clk = 1'b0, rst = 1'b1, gv = 1'b0, tr = 1'b0;
  logic [DW-1:0] dt = '0, dtb = '0, a_s = '0, d_s = '0, x = '0;
  logic [NMAX*DW-1:0] b_all = '0, c_all = '0, h_all = '0;

  logic rdy[3], vld[3], fst[3], lst[3], bsy[3];
  logic [0:0] idx[3];
  logic [DW-1:0] dto[3], dbo[3], ao[3], dno[3], xo[3];
  logic [NT*DW-1:0] bt[3], ct[3], ht[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NG = (g == 0) ? 128 : (g == 1) ? 100 : 64;
    ssm_tile_feeder #(.DW(DW), .H_TILE(1), .P_TILE(1), .N_TILE(NT), .N_TOTAL(NG)) u_dut (
      .clk(clk), .rst(rst),
      .grp_valid_i(gv), .grp_ready_o(rdy[g]),
      .dt_i(dt), .dt_bias_i(dtb), .A_i(a_s), .D_i(d_s), .x_i(x),
      .B_i(b_all[NG*DW-1:0]), .C_i(c_all[NG*DW-1:0]), .hprev_i(h_all[NG*DW-1:0]),
      .tile_valid_o(vld[g]), .tile_ready_i(tr),
      .dt_o(dto[g]), .dt_bias_o(dbo[g]), .A_o(ao[g]), .D_o(dno[g]), .x_o(xo[g]),
      .B_tile_o(bt[g]), .C_tile_o(ct[g]), .hprev_tile_o(ht[g]),
      .tile_idx_o(idx[g]), .tile_first_o(fst[g]), .tile_last_o(lst[g]), .busy_o(bsy[g]));
  end

  // Reference model: per instance, the captured group and the number of tiles still owed.
  int ntot[3] = '{128, 100, 64};
  int rem[3];
  logic [DW-1:0] m_dt[3], m_db[3], m_a[3], m_d[3], m_x[3];
  logic [NMAX*DW-1:0] m_b[3], m_c[3], m_h[3];
  int n_cmp = 0, n_bad = 0;

  function automatic int tpg(int k);
    return (ntot[k] + NT - 1) / NT;
  endfunction

  function automatic logic [NT*DW-1:0] slice(logic [NMAX*DW-1:0] src, int nt, int t);
    logic [NT*DW-1:0] r;
    r = '0;
    for (int j = 0; j < NT; j++)
      if (t*NT + j < nt) r[j*DW +: DW] = src[(t*NT + j)*DW +: DW];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0;
      m_dt[k] = '0; m_db[k] = '0; m_a[k] = '0; m_d[k] = '0; m_x[k] = '0;
      m_b[k] = '0; m_c[k] = '0; m_h[k] = '0;
    end
  endtask

  task automatic model_step();
    bit ready;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      ready = (rem[k] == 0) || (rem[k] == 1 && tr);
      if (gv && ready) begin
        m_dt[k] = dt; m_db[k] = dtb; m_a[k] = a_s; m_d[k] = d_s; m_x[k] = x;
        m_b[k] = b_all; m_c[k] = c_all; m_h[k] = h_all;
        rem[k] = tpg(k);
      end else if (rem[k] > 0 && tr) begin
        rem[k]--;
      end
    end
  endtask

  task automatic cmp(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d @%0t: got %h want %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic cmp_tile(string nm, int k, logic [NT*DW-1:0] act, logic [NT*DW-1:0] exp);
    int fj;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      fj = 0;
      for (int j = NT-1; j >= 0; j--)
        if (act[j*DW +: DW] !== exp[j*DW +: DW]) fj = j;
      $display("FAIL %s u%0d @%0t: elem %0d got %h want %h", nm, k, $time, fj,
               act[fj*DW +: DW], exp[fj*DW +: DW]);
    end
  endtask

  task automatic check_all();
    int t;
    bit v;
    for (int k = 0; k < 3; k++) begin
      v = (rem[k] != 0);
      t = v ? tpg(k) - rem[k] : 0;
      cmp("valid", k, 32'(vld[k]), 32'(v));
      cmp("grp_ready", k, 32'(rdy[k]), 32'((rem[k] == 0) || (rem[k] == 1 && tr)));
      cmp("idx", k, 32'(idx[k]), t);
      cmp("first", k, 32'(fst[k]), 32'(v && t == 0));
      cmp("last", k, 32'(lst[k]), 32'(v && t == tpg(k) - 1));
      cmp("busy", k, 32'(bsy[k]), 32'(v));
      cmp("dt", k, 32'(dto[k]), 32'(m_dt[k]));
      cmp("dt_bias", k, 32'(dbo[k]), 32'(m_db[k]));
      cmp("A", k, 32'(ao[k]), 32'(m_a[k]));
      cmp("D", k, 32'(dno[k]), 32'(m_d[k]));
      cmp("x", k, 32'(xo[k]), 32'(m_x[k]));
      cmp_tile("B_tile", k, bt[k], slice(m_b[k], ntot[k], t));
      cmp_tile("C_tile", k, ct[k], slice(m_c[k], ntot[k], t));
      cmp_tile("hprev_tile", k, ht[k], slice(m_h[k], ntot[k], t));
    end
  endtask

  // Called just after a rising edge; checks mid-cycle, advances the model at the next edge.
  task automatic cyc();
    @(negedge clk);
    if (rst) model_reset();
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_data();
    dt = 16'($urandom); dtb = 16'($urandom); a_s = 16'($urandom);
    d_s = 16'($urandom); x = 16'($urandom);
    for (int i = 0; i < NMAX*DW/32; i++) begin
      b_all[i*32 +: 32] = $urandom;
      c_all[i*32 +: 32] = $urandom;
      h_all[i*32 +: 32] = $urandom;
    end
  endtask

  typedef struct {
    logic gv, tr;
    logic [15:0] dt;
    logic ev, er, ei, ef, el;
    logic [15:0] edt;
  } vec_t;

  vec_t tbl[14];
  logic [NT*DW-1:0] e1, e2;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // gv tr dt | valid ready idx first last | dt_o  (instance u0, N_TOTAL=128)
    tbl = '{
      '{1, 1, 16'h1111, 0, 1, 0, 0, 0, 16'h0000},  // idle, accept g1
      '{0, 1, 16'h1111, 1, 0, 0, 1, 0, 16'h1111},  // g1 tile 0
      '{0, 1, 16'h1111, 1, 1, 1, 0, 1, 16'h1111},  // g1 tile 1
      '{0, 1, 16'h1111, 0, 1, 0, 0, 0, 16'h1111},  // idle again: two tiles only
      '{1, 0, 16'h2222, 0, 1, 0, 0, 0, 16'h1111},  // accept g2
      '{0, 0, 16'h2222, 1, 0, 0, 1, 0, 16'h2222},  // backpressure x3
      '{0, 0, 16'h2222, 1, 0, 0, 1, 0, 16'h2222},
      '{0, 0, 16'h2222, 1, 0, 0, 1, 0, 16'h2222},
      '{0, 1, 16'h2222, 1, 0, 0, 1, 0, 16'h2222},  // ready rises
      '{0, 0, 16'h2222, 1, 0, 1, 0, 1, 16'h2222},  // tile 1, held
      '{1, 1, 16'h3333, 1, 1, 1, 0, 1, 16'h2222},  // back-to-back accept g3
      '{0, 1, 16'h3333, 1, 0, 0, 1, 0, 16'h3333},  // g3 tile 0, no bubble
      '{0, 1, 16'h3333, 1, 1, 1, 0, 1, 16'h3333},
      '{0, 1, 16'h3333, 0, 1, 0, 0, 0, 16'h3333}
    };

    // Reset state while rst is held.
    model_reset();
    #2;
    check_all();
    cmp("rst_ready", 0, 32'(rdy[0]), 1);
    cmp("rst_valid", 0, 32'(vld[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    dtb = 16'h0AAA; a_s = 16'hBBBB; d_s = 16'h0CCC; x = 16'h0055;
    for (int n = 0; n < NMAX; n++) begin
      b_all[n*DW +: DW] = 16'(n);
      c_all[n*DW +: DW] = 16'h3C00;
      h_all[n*DW +: DW] = 16'(32'h100 + n);
    end

    for (int i = 0; i < 14; i++) begin
      gv = tbl[i].gv; tr = tbl[i].tr; dt = tbl[i].dt;
      @(negedge clk);
      cmp("tv_valid", 0, 32'(vld[0]), 32'(tbl[i].ev));
      cmp("tv_ready", 0, 32'(rdy[0]), 32'(tbl[i].er));
      cmp("tv_idx", 0, 32'(idx[0]), 32'(tbl[i].ei));
      cmp("tv_first", 0, 32'(fst[0]), 32'(tbl[i].ef));
      cmp("tv_last", 0, 32'(lst[0]), 32'(tbl[i].el));
      cmp("tv_dt", 0, 32'(dto[0]), 32'(tbl[i].edt));
      if (i == 1) begin
        for (int j = 0; j < NT; j++) begin
          e1[j*DW +: DW] = 16'(j);
          e2[j*DW +: DW] = 16'(32'h100 + j);
        end
        cmp_tile("t0_B", 0, bt[0], e1);
        cmp_tile("t0_hprev", 0, ht[0], e2);
      end
      if (i == 2) begin
        for (int j = 0; j < NT; j++) begin
          e1[j*DW +: DW] = 16'(64 + j);
          e2[j*DW +: DW] = (j < 36) ? 16'h3C00 : 16'h0000;
        end
        cmp_tile("t1_B", 0, bt[0], e1);
        cmp_tile("pad_C", 1, ct[1], e2);
        cmp("pad_idx", 1, 32'(idx[1]), 1);
        cmp("pad_last", 1, 32'(lst[1]), 1);
      end
      check_all();
      @(posedge clk);
      model_step();
      #1;
    end

    // Reset during tile 1 drops the group; next group restarts at tile 0.
    rand_data();
    gv = 1'b1; tr = 1'b1;
    cyc();
    gv = 1'b0;
    cyc();
    cmp("pre_rst_idx", 0, 32'(idx[0]), 1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cmp("rst_mid_valid", 0, 32'(vld[0]), 0);
    cmp_tile("rst_mid_B", 0, bt[0], '0);
    cyc();
    rst = 1'b0;
    rand_data();
    gv = 1'b1;
    cyc();
    cmp("restart_valid", 0, 32'(vld[0]), 1);
    cmp("restart_idx", 0, 32'(idx[0]), 0);
    gv = 1'b0;
    repeat (3) cyc();

    // TPG==1: three queued groups give three consecutive first+last tiles on u2.
    for (int g = 0; g < 3; g++) begin
      rand_data();
      dt = 16'(32'hA000 + g);
      gv = 1'b1; tr = 1'b1;
      cyc();
      cmp("tpg1_valid", 2, 32'(vld[2]), 1);
      cmp("tpg1_first", 2, 32'(fst[2]), 1);
      cmp("tpg1_last", 2, 32'(lst[2]), 1);
      cmp("tpg1_dt", 2, 32'(dto[2]), 32'hA000 + g);
    end
    gv = 1'b0;
    repeat (3) cyc();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rand_data();
      gv = 1'($urandom_range(0, 1));
      tr = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      cyc();
    end
    rst = 1'b0; gv = 1'b0; tr = 1'b1;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ssm_tile_feeder.md
Name: ssm_tile_feeder

Overview:
- Upstream stage of the SSM block.
- Accepts one full group per handshake: per-head scalars, x, full-length B/C vectors (N_TOTAL) and the full hprev state.
- Slices the group into TILES_PER_GROUP consecutive N_TILE-wide tiles and presents them on a valid/ready stream to the SSM top's tile input.
- Zero-pads the final tile when N_TOTAL is not a multiple of N_TILE, and supports back-to-back groups with no bubble.

Parameters:
- DW, 16, element width (FP16 bit pattern, not interpreted).
- H_TILE, 1, heads per group.
- P_TILE, 1, head-dim elements per head.
- N_TILE, 64, state elements per tile.
- N_TOTAL, 128, state elements per group.
- Derived localparam TPG = ceil(N_TOTAL/N_TILE); CW = max(1, clog2(TPG)).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- grp_valid_i  in  1  group offered
- grp_ready_o  out  1  group accepted when grp_valid_i & grp_ready_o
- dt_i, dt_bias_i, A_i, D_i  in  H_TILE*DW each  per-head scalars
- x_i  in  H_TILE*P_TILE*DW  x
- B_i, C_i  in  N_TOTAL*DW each  full B, C; element n at [n*DW +: DW]
- hprev_i  in  H_TILE*P_TILE*N_TOTAL*DW  element (hp,n) at [(hp*N_TOTAL+n)*DW +: DW]
- tile_valid_o  out  1  tile presented
- tile_ready_i  in  1  tile consumed when tile_valid_o & tile_ready_i
- dt_o, dt_bias_o, A_o, D_o  out  H_TILE*DW each  held copies of the captured scalars
- x_o  out  H_TILE*P_TILE*DW  held copy of captured x
- B_tile_o, C_tile_o  out  N_TILE*DW each  tile slice
- hprev_tile_o  out  H_TILE*P_TILE*N_TILE*DW  element (hp,j) at [(hp*N_TILE+j)*DW +: DW]
- tile_idx_o  out  CW  index of the presented tile, 0..TPG-1
- tile_first_o  out  1  tile_idx_o==0 while valid
- tile_last_o  out  1  tile_idx_o==TPG-1 while valid
- busy_o  out  1  state==STREAM

Behaviour:
- Reset (async, rst=1): state IDLE.
  - tile_valid_o=0, tile_idx_o=0, grp_ready_o=1.
  - All capture registers = 0, so every data output = 0.
  - Reset mid-stream discards the remaining tiles. No partial group is resumed.
- Capture registers hold the scalars, x, B, C and hprev. They load only on group accept (grp_valid_i & grp_ready_o).
- Tile output slice for tile index t, element j (0..N_TILE-1):
  - Source index n = t*N_TILE + j.
  - Output = captured[n] if n < N_TOTAL, else 0 (padding).
  - Applies to B, C and to each hp row of hprev.
  - Slices are combinational from the capture registers and the tile counter, so outputs are stable while valid and not ready.
- FSM, two states:
  - IDLE: grp_ready_o=1, tile_valid_o=0. On accept: capture, cnt<=0, go to STREAM. First tile is valid the next cycle (1-cycle latency).
  - STREAM: tile_valid_o=1.
    - On tile_ready_i with cnt<TPG-1: cnt<=cnt+1.
    - On tile_ready_i with cnt==TPG-1: if grp_valid_i, capture the new group, cnt<=0, stay in STREAM (no bubble); otherwise go to IDLE, cnt<=0.
    - No tile_ready_i: hold cnt and all outputs (AXI-style stable-while-valid).
- grp_ready_o = (state==IDLE) | (state==STREAM & cnt==TPG-1 & tile_ready_i). This is combinational from tile_ready_i, so ready depends on ready with no loop.
- grp_valid_i in STREAM with ready low: ignored; upstream must hold.
- TPG==1: every accepted tile is both first and last. Back-to-back groups give a continuous tile stream.
- Scalar and x outputs stay constant across all tiles of a group. The downstream SSM top relies on this for its xD latch.
- No arithmetic beyond index compare. Counter wrap only at TPG-1.

Test Plan:
- Defaults (N_TOTAL=128, N_TILE=64), B[n]=n, hprev[n]=0x100+n, ready=1, one group:
  - Tile 0 has B_tile[j]=j, hprev_tile[j]=0x100+j, first=1.
  - Tile 1 has B_tile[j]=64+j, last=1.
  - Then tile_valid_o=0 and busy_o=0; exactly 2 tiles total.
- N_TOTAL=100, N_TILE=64, C[n]=0x3C00:
  - Tile 1 C_tile[0..35]=0x3C00, C_tile[36..63]=0.
  - tile_idx_o=1, last=1.
- Backpressure: ready low for 3 cycles on tile 0 -> valid stays 1; all outputs and tile_idx_o=0 unchanged; advances one cycle after ready rises.
- Back-to-back: second group offered during tile 1 -> grp_ready_o high exactly on the tile-1 accept cycle; next cycle shows group 2 tile 0 (dt_o = new dt), no idle cycle.
- rst asserted during tile 1 -> outputs 0 and tile_valid_o=0 immediately; after release the next group starts at tile_idx_o=0.
- N_TOTAL=64, N_TILE=64 (TPG=1) -> each tile has first=last=1; 3 queued groups give 3 consecutive valid tiles.
